// File: rtl/instr_sequencer_if.sv
// Fetch and datapath-control bus between the instruction sequencer and
// the memory / register-file / ALU side.
interface instr_sequencer_if #(
    parameter int PC_W = 10
);
    logic [15:0]     mem_data;
    logic            mem_valid;
    logic            mem_rd;
    logic [PC_W-1:0] mem_addr;
    logic [4:0]      flags;
    logic [15:0]     opcode;
    logic            reg_wr_en;
    logic [4:0]      flag_reg;
    logic            halted;

    modport master (
        input  mem_data, mem_valid, flags,
        output mem_rd, mem_addr, opcode,
        output reg_wr_en, flag_reg, halted
    );

    modport slave (
        output mem_data, mem_valid, flags,
        input  mem_rd, mem_addr, opcode,
        input  reg_wr_en, flag_reg, halted
    );
endinterface

// File: rtl/instr_sequencer.sv
// FETCH/DECODE/EXEC sequencer driving the register-file/ALU datapath.
// Define CTRL_BRANCH_EN to build conditional branches (else 4'hC is a NOP).
module instr_sequencer #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    instr_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nx;
    logic [15:0]     ir;
    logic [4:0]      freg;
    logic            fetch_rd;
    logic            reg_wr;
    logic            halt_o;
    logic            is_halt;
    logic            is_bcc;

    assign is_halt = (ir[15:12] == 4'hF);
    assign is_bcc  = (ir[15:12] == 4'hC);

`ifdef CTRL_BRANCH_EN
    logic            cond;
    logic            taken;
    logic [PC_W-1:0] disp;

    assign disp = PC_W'($signed(ir[7:0]));

    // freg bits are {C,L,F,Z,N}
    always_comb begin
        cond = 1'b0;
        unique case (ir[11:8])
            4'h0:    cond = freg[1];
            4'h1:    cond = ~freg[1];
            4'h2:    cond = freg[4];
            4'h3:    cond = ~freg[4];
            4'h6:    cond = freg[0];
            4'h7:    cond = ~freg[0];
            4'h8:    cond = freg[2];
            4'h9:    cond = ~freg[2];
            4'hE:    cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken <= 1'b0;
        end else if (state == S_DECODE) begin
            taken <= cond;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        fetch_rd = 1'b0;
        reg_wr   = 1'b0;
        halt_o   = 1'b0;
        unique case (state)
            S_FETCH: begin
                fetch_rd = 1'b1;
                if (bus.mem_valid) begin
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                state_nx = S_FETCH;
                pc_nx    = pc + PC_W'(1);
                unique case (1'b1)
                    is_halt: begin
                        state_nx = S_HALT;
                        pc_nx    = pc;
                    end
                    is_bcc: begin
`ifdef CTRL_BRANCH_EN
                        if (taken) begin
                            pc_nx = pc + disp;
                        end
`endif
                    end
                    default: begin
                        reg_wr = 1'b1;
                    end
                endcase
            end
            S_HALT: begin
                halt_o = 1'b1;
            end
            default: begin
                state_nx = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
            freg  <= 5'd0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (fetch_rd && bus.mem_valid) begin
                ir <= bus.mem_data;
            end
            if (reg_wr) begin
                freg <= bus.flags;
            end
        end
    end

    // Reset is asynchronous, so the fetch request must also drop at once.
    assign bus.mem_rd    = fetch_rd & ~rst;
    assign bus.mem_addr  = pc;
    assign bus.opcode    = ir;
    assign bus.reg_wr_en = reg_wr;
    assign bus.flag_reg  = freg;
    assign bus.halted    = halt_o;
endmodule
